dcb_rx_buffer: RTL and testbench

DCB_RX_BUFFER -- requirements
Module: dcb_rx_buffer

---
 rtl/dcb_pkg.sv | 22 ++
 rtl/dcb_fifo_mem.sv | 33 +++
 rtl/dcb_rx_buffer.sv | 122 ++++++++++++
 tb/tb_dcb_rx_buffer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dcb_pkg.sv
// =============================================================================
// Module      : dcb_pkg
// Description : Shared constants and types for the DCB receive buffer.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package dcb_pkg;

    localparam int DCB_DATA_WIDTH = 32;
    localparam int DCB_FIFO_DEPTH = 8;

    // Per-cycle transfer decision: store, hand off to consumer, or discard.
    typedef struct packed {
        logic wr;
        logic rd;
        logic drop;
    } dcb_xfer_t;

endpackage : dcb_pkg

`default_nettype wire

// File: rtl/dcb_fifo_mem.sv
// =============================================================================
// Module      : dcb_fifo_mem
// Description : Unreset register array, one write port, one async read port.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module dcb_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_W-1:0]     i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem_q[i_rd_addr];

endmodule : dcb_fifo_mem

`default_nettype wire

// File: rtl/dcb_rx_buffer.sv
// =============================================================================
// Module      : dcb_rx_buffer
// Description : Registered FWFT receive FIFO with overflow drop counting.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module dcb_rx_buffer
    import dcb_pkg::*;
#(
    parameter int DATA_WIDTH = DCB_DATA_WIDTH,
    parameter int FIFO_DEPTH = DCB_FIFO_DEPTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          dcb_clk,
    input  logic                          dcb_rst_n,
    input  logic                          dcb_in_val,
    input  logic [DATA_WIDTH-1:0]         dcb_in_data,
    output logic                          dcb_out_val,
    output logic [DATA_WIDTH-1:0]         dcb_out_data,
    input  logic                          dcb_out_rdy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [CNT_WIDTH-1:0]          drop_cnt,
    output logic                          ovf_flag,
    input  logic                          ovf_clr
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_lvl_w = c_ptr_w + 1;
    localparam logic [c_lvl_w-1:0] c_full_lvl = c_lvl_w'(FIFO_DEPTH);

    logic [c_ptr_w-1:0]    wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]    rd_ptr_q, rd_ptr_d;
    logic [c_lvl_w-1:0]    level_q, level_d;
    logic [c_lvl_w-1:0]    remaining;
    logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  full;
    dcb_xfer_t             xfer;

    assign full = (level_q == c_full_lvl);

    always_comb begin
        xfer.wr   = dcb_in_val & ~full;
        xfer.rd   = (level_q != '0) & dcb_out_rdy;
        xfer.drop = dcb_in_val & full;

        wr_ptr_d  = wr_ptr_q + c_ptr_w'(xfer.wr);
        rd_ptr_d  = rd_ptr_q + c_ptr_w'(xfer.rd);
        level_d   = level_q + c_lvl_w'(xfer.wr) - c_lvl_w'(xfer.rd);
        remaining = level_q - c_lvl_w'(xfer.rd);

        // Next head comes straight from the input when nothing older survives the edge.
        out_data_d = out_data_q;
        if (xfer.wr && (remaining == '0)) begin
            out_data_d = dcb_in_data;
        end else if (xfer.rd) begin
            out_data_d = mem_rdata;
        end

        drop_cnt_d = drop_cnt_q;
        if (xfer.drop) begin
            if (ovf_clr) begin
                drop_cnt_d = CNT_WIDTH'(1);
            end else if (!(&drop_cnt_q)) begin
                drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
            end
        end else if (ovf_clr) begin
            drop_cnt_d = '0;
        end

        ovf_d = xfer.drop | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge dcb_clk or negedge dcb_rst_n) begin
        if (!dcb_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge dcb_clk) begin
        out_data_q <= out_data_d;
    end

    dcb_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_W     (c_ptr_w)
    ) u_mem (
        .clk        (dcb_clk),
        .i_wr_en    (xfer.wr),
        .i_wr_addr  (wr_ptr_q),
        .i_wr_data  (dcb_in_data),
        .i_rd_addr  (rd_ptr_d),
        .o_rd_data  (mem_rdata)
    );

    assign dcb_out_val  = (level_q != '0);
    assign dcb_out_data = out_data_q;
    assign fifo_level   = level_q;
    assign fifo_full    = full;
    assign fifo_empty   = (level_q == '0);
    assign drop_cnt     = drop_cnt_q;
    assign ovf_flag     = ovf_q;

endmodule : dcb_rx_buffer

`default_nettype wire

// File: tb/tb_dcb_rx_buffer.sv
// =============================================================================
// Module      : tb_dcb_rx_buffer
// Description : Queue-model bench for dcb_rx_buffer (16-bit and 4-bit counters).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_dcb_rx_buffer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_val = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_rdy = 1'b0;
    logic        clr = 1'b0;

    logic        a_val, b_val, a_full, b_full, a_empty, b_empty, a_ovf, b_ovf;
    logic [31:0] a_data, b_data;
    logic [3:0]  a_lvl, b_lvl;
    logic [15:0] a_cnt;
    logic [3:0]  b_cnt;

    int errors = 0;
    int checks = 0;

    // Reference state: contents in order, drop counts for both counter widths.
    logic [31:0] mq[$];
    int          m_cnt16 = 0;
    int          m_cnt4  = 0;
    bit          m_ovf   = 0;

    always #5 clk = ~clk;

    dcb_rx_buffer u_dut (
        .dcb_clk(clk), .dcb_rst_n(rst_n), .dcb_in_val(in_val), .dcb_in_data(in_data),
        .dcb_out_val(a_val), .dcb_out_data(a_data), .dcb_out_rdy(out_rdy),
        .fifo_level(a_lvl), .fifo_full(a_full), .fifo_empty(a_empty),
        .drop_cnt(a_cnt), .ovf_flag(a_ovf), .ovf_clr(clr)
    );

    dcb_rx_buffer #(.CNT_WIDTH(4)) u_dut4 (
        .dcb_clk(clk), .dcb_rst_n(rst_n), .dcb_in_val(in_val), .dcb_in_data(in_data),
        .dcb_out_val(b_val), .dcb_out_data(b_data), .dcb_out_rdy(out_rdy),
        .fifo_level(b_lvl), .fifo_full(b_full), .fifo_empty(b_empty),
        .drop_cnt(b_cnt), .ovf_flag(b_ovf), .ovf_clr(clr)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_cnt16 = 0;
            m_cnt4  = 0;
            m_ovf   = 0;
        end else begin
            bit full, drop;
            full = (mq.size() == DEPTH);
            drop = in_val && full;
            if (mq.size() != 0 && out_rdy) void'(mq.pop_front());
            if (in_val && !full) mq.push_back(in_data);
            if (drop) begin
                m_cnt16 = clr ? 1 : ((m_cnt16 < 65535) ? m_cnt16 + 1 : 65535);
                m_cnt4  = clr ? 1 : ((m_cnt4 < 15) ? m_cnt4 + 1 : 15);
                m_ovf   = 1;
            end else if (clr) begin
                m_cnt16 = 0;
                m_cnt4  = 0;
                m_ovf   = 0;
            end
        end
    end

    always @(negedge clk) begin
        int n;
        n = mq.size();
        chk("val",     a_val,   (n != 0));
        chk("val4",    b_val,   (n != 0));
        chk("level",   a_lvl,   n);
        chk("level4",  b_lvl,   n);
        chk("full",    a_full,  (n == DEPTH));
        chk("empty",   a_empty, (n == 0));
        chk("full4",   b_full,  (n == DEPTH));
        chk("empty4",  b_empty, (n == 0));
        chk("ovf",     a_ovf,   m_ovf);
        chk("ovf4",    b_ovf,   m_ovf);
        chk("cnt16",   a_cnt,   m_cnt16);
        chk("cnt4",    b_cnt,   m_cnt4);
        if (n != 0) begin
            chk("data",  a_data, mq[0]);
            chk("data4", b_data, mq[0]);
        end
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic c);
        in_val  = v;
        in_data = d;
        out_rdy = r;
        clr     = c;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int prob;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_val",   a_val,   1'b0);
        chk("rst_level", a_lvl,   4'd0);
        chk("rst_empty", a_empty, 1'b1);
        chk("rst_full",  a_full,  1'b0);
        chk("rst_cnt",   a_cnt,   16'd0);
        chk("rst_ovf",   a_ovf,   1'b0);
        tick();
        rst_n = 1'b1;

        // Three words streamed through with the consumer always ready.
        drive(1, 32'h11, 1, 0); tick();
        chk("s1_w0", a_data, 64'h11); chk("s1_v0", a_val, 1'b1);
        drive(1, 32'h22, 1, 0); tick();
        chk("s1_w1", a_data, 64'h22); chk("s1_l1", a_lvl, 4'd1);
        drive(1, 32'h33, 1, 0); tick();
        chk("s1_w2", a_data, 64'h33);
        drive(0, 32'h0, 1, 0); tick();
        chk("s1_empty", a_empty, 1'b1);

        // Ten writes into eight slots with the consumer stalled.
        for (int i = 0; i < 10; i++) begin
            drive(1, i, 0, 0); tick();
        end
        drive(0, 32'h0, 0, 0); tick();
        chk("s2_level", a_lvl, 4'd8);
        chk("s2_full",  a_full, 1'b1);
        chk("s2_cnt",   a_cnt, 16'd2);
        chk("s2_ovf",   a_ovf, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(0, 32'h0, 1, 0);
            chk("s2_drain", a_data, i);
            tick();
        end
        chk("s2_empty", a_empty, 1'b1);

        // Drop while reading from a full buffer.
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h100 + i, 0, 0); tick();
        end
        drive(1, 32'hAA, 1, 0); tick();
        chk("s3_level", a_lvl, 4'd7);
        chk("s3_cnt",   a_cnt, 16'd3);
        drive(1, 32'hBB, 0, 0); tick();
        chk("s3_refill", a_lvl, 4'd8);

        // Clear coincident with a drop, then clear alone.
        drive(1, 32'hCC, 0, 1); tick();
        chk("s4_ovf", a_ovf, 1'b1);
        chk("s4_cnt", a_cnt, 16'd1);
        drive(0, 32'h0, 0, 1); tick();
        chk("s4_ovf_clr", a_ovf, 1'b0);
        chk("s4_cnt_clr", a_cnt, 16'd0);

        // Stalled head stays put, then reset acts without a clock edge.
        drive(0, 32'h0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s5_hold", a_data, 64'h101);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("s5_async_val",   a_val, 1'b0);
        chk("s5_async_level", a_lvl, 4'd0);
        tick();
        rst_n = 1'b1;
        drive(1, 32'h55, 0, 0); tick();
        chk("s5_post_rst", a_data, 64'h55);
        chk("s5_post_lvl", a_lvl, 4'd1);
        drive(0, 32'h0, 1, 0); tick();

        // Twenty drops saturate the 4-bit counter.
        for (int i = 0; i < 28; i++) begin
            drive(1, 32'h200 + i, 0, 0); tick();
        end
        drive(0, 32'h0, 0, 0); tick();
        chk("s6_cnt16", a_cnt, 16'd20);
        chk("s6_cnt4",  b_cnt, 4'hF);
        drive(0, 32'h0, 1, 1); tick();
        drive(0, 32'h0, 1, 0);
        for (int i = 0; i < 8; i++) tick();

        // Randomised traffic with alternating consumer pressure.
        prob = 20;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) prob = (prob == 20) ? 85 : 20;
            drive(($urandom % 4) != 0, $urandom,
                  ($urandom_range(0, 99) < prob), ($urandom % 16) == 0);
            tick();
        end
        drive(0, 32'h0, 1, 0);
        for (int i = 0; i < 10; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_dcb_rx_buffer

`default_nettype wire
